// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// lz_mask works on a fixed maximum width so it can serve any digit count.
package seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         MAX_DIGITS = 16;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } scan_state_t;

    // Bit i set when digit i (i>0) and every more significant digit are zero.
    // Digit 0 is never masked so an all-zero value still shows "0".
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] shadow,
        input int                      num_digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int i = MAX_DIGITS-1; i >= 0; i--) begin
            if (i < num_digits) begin
                upper_zero = upper_zero & (shadow[4*i +: 4] == 4'h0);
                if (i != 0) mask[i] = upper_zero;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Slot timer: counts 0..REFRESH_DIV-1 and flags the last dead cycle
// and the last cycle of each slot.
module seg_refresh_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic dead_end,
    output logic slot_end
);
    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign dead_end = (cnt_q == DEAD_LAST);
    assign slot_end = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display:
// dead time per slot, leading-zero blanking, global blank and frame pulse.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int LZ_BLANK    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          blank_all,
    output logic [3:0]                    bin,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);
    localparam int             IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic                    dead_end, slot_end;
    scan_state_t             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              bin_q, bin_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    lit_q, lit_d;
    logic                    frame_q, frame_d;

    logic [4*MAX_DIGITS-1:0] shadow_ext;
    logic [MAX_DIGITS-1:0]   blank_mask;
    logic [3:0]              cur_code;
    logic                    cur_blank;

    seg_refresh_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .dead_end (dead_end),
        .slot_end (slot_end)
    );

    always_comb begin
        shadow_ext                   = '0;
        shadow_ext[4*NUM_DIGITS-1:0] = shadow_q;
    end

    assign blank_mask = lz_mask(shadow_ext, NUM_DIGITS);

    // Code and blank decision for the slot about to be captured.
    always_comb begin
        cur_code  = BLANK_CODE;
        cur_blank = 1'b0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < NUM_DIGITS && idx_q == IDX_W'(i)) begin
                cur_code  = shadow_ext[4*i +: 4];
                cur_blank = (LZ_BLANK != 0) && blank_mask[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bin_d    = bin_q;
        lit_d    = lit_q;
        frame_d  = 1'b0;
        shadow_d = load ? digits_in : shadow_q;
        case (state_q)
            DEAD: if (dead_end) begin
                state_d = ON;
                lit_d   = !cur_blank;
                bin_d   = cur_blank ? BLANK_CODE : cur_code;
            end
            ON: if (slot_end) begin
                state_d = DEAD;
                lit_d   = 1'b0;
                bin_d   = BLANK_CODE;
                frame_d = (idx_q == IDX_LAST);
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            default: state_d = DEAD;
        endcase

        // blank_all only gates the anodes; everything else keeps running.
        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (state_d == ON && lit_d && !blank_all && idx_d == IDX_W'(i))
                an_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DEAD;
            shadow_q <= '0;
            idx_q    <= '0;
            bin_q    <= BLANK_CODE;
            an_q     <= '1;
            lit_q    <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            bin_q    <= bin_d;
            an_q     <= an_d;
            lit_q    <= lit_d;
            frame_q  <= frame_d;
        end
    end

    assign bin        = bin_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: slot-arithmetic reference model checked every cycle,
// plus hand-computed expectations at key points of each directed scenario.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, load, blank_all;
    logic [15:0] digits_in;
    logic [3:0]  bin;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state: t = clock edges since the last reset edge.
    int          t = 0;
    bit          m_ok = 1'b0;
    logic [15:0] m_sh = '0;
    logic [3:0]  cap_code = 4'hF;
    bit          cap_lit = 1'b0;
    bit          prev_blank = 1'b0;

    seg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2),
        .LZ_BLANK    (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digits_in  (digits_in),
        .blank_all  (blank_all),
        .bin        (bin),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0d)", nm, act, exp, t);
        end
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int k);
        logic [3:0] r;
        r = 4'h0;
        for (int j = 0; j < 4; j++) if (j == k) r = v[4*j +: 4];
        return r;
    endfunction

    // Model: slot = t/8, digit = slot%4, code latched at the edge leaving cnt==1.
    always @(posedge clk) begin
        int  idx, cnt;
        bit  lit;
        logic [3:0] e_an, e_bin;
        if (!rst_n) begin
            t = 0; m_sh = '0; cap_code = 4'hF; cap_lit = 1'b0; prev_blank = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (t % 8 == 1) begin
                idx = (t / 8) % 4;
                lit = (idx == 0);
                for (int j = 0; j < 4; j++) if (j >= idx && nib(m_sh, j) != 4'h0) lit = 1'b1;
                cap_lit  = lit;
                cap_code = lit ? nib(m_sh, idx) : 4'hF;
            end
            if (load) m_sh = digits_in;
            prev_blank = blank_all;
            t++;
        end
        #1;
        if (m_ok) begin
            cnt   = t % 8;
            idx   = (t / 8) % 4;
            e_bin = (cnt < 2) ? 4'hF : cap_code;
            e_an  = 4'hF;
            if (cnt >= 2 && cap_lit && !prev_blank) e_an[idx] = 1'b0;
            chk("model_an", {12'h0, an}, {12'h0, e_an});
            chk("model_bin", {12'h0, bin}, {12'h0, e_bin});
            chk("model_idx", {14'h0, digit_idx}, 16'(idx));
            chk("model_frame", {15'h0, frame_done}, {15'h0, (t > 0 && t % 32 == 0)});
        end
    end

    task automatic adv_to(input int target);
        int n;
        n = 0;
        while (t != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (t != target) begin
            errors++;
            $display("FAIL adv_to timeout got t=%0d want t=%0d", t, target);
        end
    endtask

    task automatic lit(input string nm, input logic [3:0] e_an, input logic [3:0] e_bin);
        chk({nm, "_an"}, {12'h0, an}, {12'h0, e_an});
        chk({nm, "_bin"}, {12'h0, bin}, {12'h0, e_bin});
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; digits_in = '0; blank_all = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset", 4'hF, 4'hF);
        chk("reset_frame", {15'h0, frame_done}, 16'h0);
        chk("reset_idx", {14'h0, digit_idx}, 16'h0);

        // 1: plain scan of 1234
        rst_n = 1'b1; load = 1'b1; digits_in = 16'h1234;
        adv_to(1);  load = 1'b0; lit("s1_dead", 4'hF, 4'hF);
        adv_to(2);  lit("s1_d0", 4'hE, 4'h4);
        adv_to(10); lit("s1_d1", 4'hD, 4'h3);
        adv_to(18); lit("s1_d2", 4'hB, 4'h2);
        adv_to(26); lit("s1_d3", 4'h7, 4'h1);
        adv_to(31); chk("s1_frame_lo", {15'h0, frame_done}, 16'h0);
        adv_to(32); chk("s1_frame_hi", {15'h0, frame_done}, 16'h1);

        // 2: leading-zero blanking
        load = 1'b1; digits_in = 16'h0070;
        adv_to(33); load = 1'b0;
        adv_to(34); lit("s2_d0", 4'hE, 4'h0);
        adv_to(42); lit("s2_d1", 4'hD, 4'h7);
        adv_to(50); lit("s2_d2", 4'hF, 4'hF);
        adv_to(58); lit("s2_d3", 4'hF, 4'hF);
        adv_to(64); load = 1'b1; digits_in = 16'h0000;
        adv_to(65); load = 1'b0;
        adv_to(66); lit("s2_zero_d0", 4'hE, 4'h0);
        adv_to(74); lit("s2_zero_d1", 4'hF, 4'hF);

        // 3: load coinciding with the digit-1 capture edge
        adv_to(96);  load = 1'b1; digits_in = 16'h5555;
        adv_to(97);  load = 1'b0;
        adv_to(105); load = 1'b1; digits_in = 16'h9999;
        adv_to(106); load = 1'b0; lit("s3_d1_old", 4'hD, 4'h5);
        adv_to(114); lit("s3_d2_new", 4'hB, 4'h9);

        // 4: blank_all for 3 cycles mid-ON of digit 2
        adv_to(115); lit("s4_pre", 4'hB, 4'h9); blank_all = 1'b1;
        adv_to(116); lit("s4_b1", 4'hF, 4'h9);
        adv_to(118); blank_all = 1'b0; lit("s4_b3", 4'hF, 4'h9);
        adv_to(119); lit("s4_rel", 4'hB, 4'h9);
        adv_to(122); lit("s4_d3", 4'h7, 4'h9);

        // 5: reset mid-ON of digit 3
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lit("s5_rst", 4'hF, 4'hF);
        chk("s5_idx", {14'h0, digit_idx}, 16'h0);
        chk("s5_frame", {15'h0, frame_done}, 16'h0);
        adv_to(2);  lit("s5_d0", 4'hE, 4'h0);
        adv_to(10); lit("s5_d1", 4'hF, 4'hF);

        // 6: codes above 9 count as nonzero
        adv_to(32); chk("s6_frame", {15'h0, frame_done}, 16'h1);
        load = 1'b1; digits_in = 16'hA0B3;
        adv_to(33); load = 1'b0;
        adv_to(34); lit("s6_d0", 4'hE, 4'h3);
        adv_to(42); lit("s6_d1", 4'hD, 4'hB);
        adv_to(50); lit("s6_d2", 4'hB, 4'h0);
        adv_to(58); lit("s6_d3", 4'h7, 4'hA);
        adv_to(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
